// File: rtl/ptw_mem_arbiter.sv
// ptw_mem_arbiter: shares one memory read port between the IFU and LSU
// page-table walkers with round-robin arbitration and one read in flight.
// A flush from the owning walker drops its pending response. A response
// timeout returns a zero PTE (V=0), so a hung fabric becomes a page fault.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req_i/if_addr_i/if_flush_i   IFU walk request, PTE address, flush
//   if_rdata_o/if_rvalid_o          IFU response data and 1-cycle strobe
//   ls_req_i/ls_addr_i/ls_flush_i   LSU walk request, PTE address, flush
//   ls_rdata_o/ls_rvalid_o          LSU response data and 1-cycle strobe
//   mem_req_o/mem_addr_o            memory read request and address
//   mem_ready_i                     memory accepts the request
//   mem_rdata_i/mem_rvalid_i        memory read data and valid
//   busy_o                          a walk read is in progress
//   owner_o                         current or last grant (0 IFU, 1 LSU)
//   timeout_err_o                   pulse in the cycle a timeout fires
module ptw_mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_rvalid_o,
    input  logic              ls_req_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic              ls_flush_i,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              ls_rvalid_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              busy_o,
    output logic              owner_o,
    output logic              timeout_err_o
);

    localparam int unsigned CNT_RAW    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W      = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                drop_q, drop_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                if_elig;
    logic                ls_elig;
    logic                owner_flush;
    logic                winner;
    logic                timeout_fire;
    logic                resp_cyc;

    assign if_elig     = if_req_i & ~if_flush_i;
    assign ls_elig     = ls_req_i & ~ls_flush_i;
    assign owner_flush = owner_q ? ls_flush_i : if_flush_i;

    // State and transaction registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b1;
            addr_q  <= '0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    // Arbitration, handshake sequencing and timeout detection
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        drop_d       = drop_q;
        cnt_d        = cnt_q;
        winner       = owner_q;
        timeout_fire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (if_elig || ls_elig) begin
                    // On a tie the requester that did not win last time goes next
                    winner  = (if_elig && ls_elig) ? ~owner_q : ls_elig;
                    owner_d = winner;
                    addr_d  = winner ? ls_addr_i : if_addr_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (owner_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (owner_flush) begin
                    drop_d = 1'b1;
                end
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Real data beats a timeout landing in the same cycle
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    timeout_fire = 1'b1;
                    state_d      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Late data from a timed-out read is swallowed here
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Zero-latency response path; a timeout substitutes an invalid PTE
    assign resp_cyc      = (state_q == ST_WAIT) & (mem_rvalid_i | timeout_fire);
    assign if_rvalid_o   = resp_cyc & ~owner_q & ~drop_q & ~if_flush_i;
    assign ls_rvalid_o   = resp_cyc &  owner_q & ~drop_q & ~ls_flush_i;
    assign if_rdata_o    = timeout_fire ? '0 : mem_rdata_i;
    assign ls_rdata_o    = timeout_fire ? '0 : mem_rdata_i;

    assign mem_req_o     = (state_q == ST_REQ);
    assign mem_addr_o    = addr_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign owner_o       = owner_q;
    assign timeout_err_o = timeout_fire;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// tb_ptw_mem_arbiter: directed scenarios followed by randomized walker and
// memory traffic, every cycle compared against a transaction-level model.
module tb_ptw_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          T  = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req, if_flush, ls_req, ls_flush;
    logic [AW-1:0] if_addr, ls_addr;
    logic [DW-1:0] if_rdata_o, ls_rdata_o;
    logic          if_rvalid_o, ls_rvalid_o;
    logic          mem_req_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          busy_o, owner_o, timeout_err_o;

    int n_checks = 0;
    int n_errors = 0;

    ptw_mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_flush_i    (if_flush),
        .if_rdata_o    (if_rdata_o),
        .if_rvalid_o   (if_rvalid_o),
        .ls_req_i      (ls_req),
        .ls_addr_i     (ls_addr),
        .ls_flush_i    (ls_flush),
        .ls_rdata_o    (ls_rdata_o),
        .ls_rvalid_o   (ls_rvalid_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ready_i   (mem_ready),
        .mem_rdata_i   (mem_rdata),
        .mem_rvalid_i  (mem_rvalid),
        .busy_o        (busy_o),
        .owner_o       (owner_o),
        .timeout_err_o (timeout_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: one walk record at a time
    bit          m_owner;
    logic [31:0] m_addr;
    bit          m_pending;    // granted, not yet accepted by memory
    bit          m_inflight;   // accepted, awaiting read data
    bit          m_abandoned;  // timed out, waiting for the late data
    bit          m_flushed;    // owner flushed; response must not reach it
    int          m_age;        // cycles spent waiting for data

    // Expected values for the current cycle
    bit          e_to, e_if_rv, e_ls_rv;
    logic [31:0] e_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner     = 1'b1;
        m_addr      = '0;
        m_pending   = 1'b0;
        m_inflight  = 1'b0;
        m_abandoned = 1'b0;
        m_flushed   = 1'b0;
        m_age       = 0;
    endtask

    // Settle combinational outputs and compare everything against the model
    task automatic eval();
        bit live;
        #2;
        e_to    = m_inflight && !m_abandoned && !mem_rvalid && (m_age == T - 1);
        live    = m_inflight && !m_abandoned && (mem_rvalid || e_to);
        e_if_rv = live && !m_owner && !m_flushed && !if_flush;
        e_ls_rv = live &&  m_owner && !m_flushed && !ls_flush;
        e_rdata = e_to ? 32'd0 : mem_rdata;
        check("busy",     32'(busy_o),        32'(m_pending || m_inflight));
        check("mem_req",  32'(mem_req_o),     32'(m_pending));
        check("mem_addr", mem_addr_o,         m_addr);
        check("owner",    32'(owner_o),       32'(m_owner));
        check("timeout",  32'(timeout_err_o), 32'(e_to));
        check("if_rv",    32'(if_rvalid_o),   32'(e_if_rv));
        check("ls_rv",    32'(ls_rvalid_o),   32'(e_ls_rv));
        check("if_rdata", if_rdata_o,         e_rdata);
        check("ls_rdata", ls_rdata_o,         e_rdata);
    endtask

    // Advance the model by the clock edge using this cycle's inputs
    task automatic model_update();
        bit if_ok, ls_ok, win, oflush;
        oflush = m_owner ? ls_flush : if_flush;
        if (!rst_n) begin
            model_reset();
        end else if (!m_pending && !m_inflight) begin
            if_ok = if_req && !if_flush;
            ls_ok = ls_req && !ls_flush;
            if (if_ok || ls_ok) begin
                win       = (if_ok && ls_ok) ? !m_owner : ls_ok;
                m_owner   = win;
                m_addr    = win ? ls_addr : if_addr;
                m_pending = 1'b1;
                m_flushed = 1'b0;
            end
        end else if (m_pending) begin
            if (oflush) m_flushed = 1'b1;
            if (mem_ready) begin
                m_pending   = 1'b0;
                m_inflight  = 1'b1;
                m_abandoned = 1'b0;
                m_age       = 0;
            end
        end else begin
            if (!m_abandoned && oflush) m_flushed = 1'b1;
            if (mem_rvalid) begin
                m_inflight  = 1'b0;
                m_abandoned = 1'b0;
                m_flushed   = 1'b0;
            end else begin
                if (e_to) m_abandoned = 1'b1;
                m_age++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        eval();
        step();
    endtask

    // One complete read for a walker that is about to win arbitration
    task automatic serve(input bit who, input int lat, input logic [31:0] addr,
                         input logic [31:0] data);
        cyc();
        mem_ready = 1'b1;
        eval();
        check("grant_owner", 32'(owner_o), 32'(who));
        check("grant_req",   32'(mem_req_o), 32'd1);
        check("grant_addr",  mem_addr_o, addr);
        step();
        mem_ready = 1'b0;
        repeat (lat) cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        eval();
        check("resp_if",    32'(if_rvalid_o), 32'(!who));
        check("resp_ls",    32'(ls_rvalid_o), 32'(who));
        check("resp_data",  who ? ls_rdata_o : if_rdata_o, data);
        check("resp_no_to", 32'(timeout_err_o), 32'd0);
        step();
        mem_rvalid = 1'b0;
    endtask

    initial begin
        bit          if_done, ls_done, mem_out;
        int          mem_lat;

        rst_n = 1'b0;
        if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_flush = 1'b0; ls_addr = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        eval();
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_req",   32'(mem_req_o), 32'd0);
        check("rst_addr",  mem_addr_o, 32'd0);
        check("rst_owner", 32'(owner_o), 32'd1);
        check("rst_to",    32'(timeout_err_o), 32'd0);
        step();

        // Single IFU read
        if_req  = 1'b1;
        if_addr = 32'h8000_1004;
        serve(1'b0, 1, 32'h8000_1004, 32'h2000_0C01);
        if_req = 1'b0;
        cyc();

        // Both request from reset: IF, LS, IF, LS (last one hits the timeout cycle)
        rst_n = 1'b0;
        cyc();
        rst_n   = 1'b1;
        if_req  = 1'b1; if_addr = 32'h0000_1000;
        ls_req  = 1'b1; ls_addr = 32'h0000_2000;
        serve(1'b0, 1, 32'h0000_1000, 32'h1111_0001);
        serve(1'b1, 2, 32'h0000_2000, 32'h2222_0001);
        serve(1'b0, 0, 32'h0000_1000, 32'h3333_0001);
        serve(1'b1, 3, 32'h0000_2000, 32'h4444_0001);
        if_req = 1'b0; ls_req = 1'b0;
        cyc();

        // LSU flush during its wait; IFU granted right after the dropped data
        ls_req = 1'b1; ls_addr = 32'h0000_3000;
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        ls_flush = 1'b1;
        cyc();
        ls_flush = 1'b0; ls_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_4000;
        cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_0001;
        eval();
        check("flush_ls_rv", 32'(ls_rvalid_o), 32'd0);
        step();
        mem_rvalid = 1'b0;
        eval();
        check("flush_idle", 32'(busy_o), 32'd0);
        step();
        mem_ready = 1'b1;
        eval();
        check("flush_next_owner", 32'(owner_o), 32'd0);
        check("flush_next_req",   32'(mem_req_o), 32'd1);
        check("flush_next_addr",  mem_addr_o, 32'h0000_4000);
        step();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h6666_0001;
        cyc();
        mem_rvalid = 1'b0; if_req = 1'b0;
        cyc();

        // Timeout with no data, then drain the late response
        if_req = 1'b1; if_addr = 32'h0000_5000;
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        repeat (T - 1) cyc();
        eval();
        check("to_pulse", 32'(timeout_err_o), 32'd1);
        check("to_if_rv", 32'(if_rvalid_o), 32'd1);
        check("to_rdata", if_rdata_o, 32'd0);
        check("to_ls_rv", 32'(ls_rvalid_o), 32'd0);
        step();
        if_req = 1'b0;
        repeat (3) cyc();
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_0001;
        eval();
        check("drain_busy", 32'(busy_o), 32'd1);
        check("drain_if_rv", 32'(if_rvalid_o), 32'd0);
        step();
        mem_rvalid = 1'b0;
        cyc();

        // Memory stalls the request; REQ is not timed
        ls_req = 1'b1; ls_addr = 32'h0000_6000;
        cyc();
        for (int i = 0; i < 10; i++) begin
            eval();
            check("stall_req",  32'(mem_req_o), 32'd1);
            check("stall_addr", mem_addr_o, 32'h0000_6000);
            check("stall_to",   32'(timeout_err_o), 32'd0);
            step();
        end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h8888_0001;
        cyc();
        mem_rvalid = 1'b0; ls_req = 1'b0;
        cyc();

        // Reset while waiting; late data is ignored
        if_req = 1'b1; if_addr = 32'h0000_7000;
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
        rst_n = 1'b0; if_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        eval();
        check("mrst_busy",  32'(busy_o), 32'd0);
        check("mrst_req",   32'(mem_req_o), 32'd0);
        check("mrst_addr",  mem_addr_o, 32'd0);
        check("mrst_owner", 32'(owner_o), 32'd1);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h9999_0001;
        eval();
        check("mrst_if_rv", 32'(if_rvalid_o), 32'd0);
        step();
        mem_rvalid = 1'b0;

        // Randomized traffic
        if_done = 1'b0; ls_done = 1'b0; mem_out = 1'b0; mem_lat = 0;
        for (int c = 0; c < 4000; c++) begin
            rst_n      = ($urandom_range(0, 499) != 0);
            mem_ready  = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            mem_rvalid = 1'b0;
            if (mem_out) begin
                if (mem_lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_out    = 1'b0;
                end else begin
                    mem_lat--;
                end
            end
            if (if_req && if_done) if_req = 1'b0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (ls_req && ls_done) ls_req = 1'b0;
            else if (!ls_req && $urandom_range(0, 2) == 0) begin
                ls_req  = 1'b1;
                ls_addr = $urandom;
            end
            if_flush = ($urandom_range(0, 19) == 0);
            ls_flush = ($urandom_range(0, 19) == 0);
            eval();
            if_done = e_if_rv || if_flush;
            ls_done = e_ls_rv || ls_flush;
            if (!rst_n) begin
                mem_out = 1'b0;
            end else if (m_pending && mem_ready) begin
                mem_out = 1'b1;
                mem_lat = $urandom_range(0, 7);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
